// File: rtl/serial_parity_frame_ctrl.sv
// Framed LSB-first serial transmitter with generated parity bit.
// Optional stop-bit slot after parity: define SPFC_STOP_BIT_EN.
module serial_parity_frame_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SPFC_STOP_BIT_EN
    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             par;

    // Outputs are registered alongside the state, so each branch loads the
    // values belonging to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            in_ready   <= 1'b1;
            ser_out    <= 1'b1;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg     <= in_data;
                        cnt       <= '0;
                        par       <= ODD_PARITY;
                        state     <= DATA;
                        ser_out   <= in_data[0];
                        ser_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DATA: begin
                    if (ser_en) begin
                        par   <= par ^ shreg[0];
                        shreg <= shreg >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state   <= PAR;
                            ser_out <= par ^ shreg[0];
                        end else begin
                            ser_out <= shreg[1];
                        end
                    end
                end
                PAR: begin
                    if (ser_en) begin
`ifdef SPFC_STOP_BIT_EN
                        state   <= STOP;
                        ser_out <= 1'b1;
`else
                        state      <= IDLE;
                        ser_out    <= 1'b1;
                        ser_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
`endif
                    end
                end
`ifdef SPFC_STOP_BIT_EN
                STOP: begin
                    if (ser_en) begin
                        state      <= IDLE;
                        ser_out    <= 1'b1;
                        ser_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    ser_out   <= 1'b1;
                    ser_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
